pipe_stage_elastic: RTL and testbench

Generic parametrised pipeline stage register for the RISC-V core. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. The block carries a control bundle and a data bundle and uses a valid/ready handshake, so back-pressure is supported. It provides synchronous flush with bubble insertion, an optional 2-entry skid buffer that makes in_ready a registered signal, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_elastic.sv | 118 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: a control and a data bundle under a valid/ready handshake.
// It supports an optional 2-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned DATA_W   = 192,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CLR_DATA = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit HasSkid = (SKID != 0);
  localparam bit ClrData = (CLR_DATA != 0);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e             state_q;
  logic [CTRL_W-1:0]  main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]  main_data_q, skid_data_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               acc, pop;

  assign out_valid = (state_q != StEmpty);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // With the skid buffer, ready is decoded from the state flop only, never from out_ready.
  if (HasSkid) begin : g_skid_ready
    assign in_ready = (state_q != StTwo);
  end else begin : g_pass_ready
    assign in_ready = !out_valid || out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end

      if (flush) begin
        // The input offered this cycle is dropped; a pop this cycle has already completed.
        state_q     <= StEmpty;
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
        if (ClrData) begin
          main_data_q <= '0;
          skid_data_q <= '0;
        end
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (acc) begin
              state_q     <= StOne;
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end
          end
          StOne: begin
            if (acc && pop) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end else if (acc && HasSkid) begin
              state_q     <= StTwo;
              skid_ctrl_q <= in_ctrl;
              skid_data_q <= in_data;
            end else if (pop) begin
              // Head empties: leave a bubble behind.
              state_q     <= StEmpty;
              main_ctrl_q <= '0;
              if (ClrData) begin
                main_data_q <= '0;
              end
            end
          end
          StTwo: begin
            if (pop) begin
              state_q     <= StOne;
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              skid_ctrl_q <= '0;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic covering three configurations:
// a skid buffer with data clearing, a pass-through stage, and a skid buffer holding data with a 2-bit counter.
module tb_pipe_stage_elastic;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;

  // DUT a: SKID=1, CLR_DATA=1, CNT_W=16
  logic          flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [CW-1:0] in_ctrl_a, out_ctrl_a;
  logic [DW-1:0] in_data_a, out_data_a;
  logic [1:0]    occ_a;
  logic [15:0]   stall_a;
  // DUT b: SKID=0, CLR_DATA=1, CNT_W=16
  logic          flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [CW-1:0] in_ctrl_b, out_ctrl_b;
  logic [DW-1:0] in_data_b, out_data_b;
  logic [1:0]    occ_b;
  logic [15:0]   stall_b;
  // DUT c: SKID=1, CLR_DATA=0, CNT_W=2
  logic          flush_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [CW-1:0] in_ctrl_c, out_ctrl_c;
  logic [DW-1:0] in_data_c, out_data_c;
  logic [1:0]    occ_c;
  logic [1:0]    stall_c;

  int total = 0;
  int bad   = 0;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl_a), .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_ctrl(out_ctrl_a), .out_data(out_data_a), .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl_b), .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .occupancy(occ_b), .stall_cnt(stall_b)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_ctrl(in_ctrl_c), .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_ctrl(out_ctrl_c), .out_data(out_data_c), .occupancy(occ_c), .stall_cnt(stall_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp [6];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0;
    {flush_a, in_valid_a, out_ready_a, flush_b, in_valid_b, out_ready_b} = '0;
    {flush_c, in_valid_c, out_ready_c} = '0;
    in_ctrl_a = '0; in_data_a = '0; in_ctrl_b = '0; in_data_b = '0;
    in_ctrl_c = '0; in_data_c = '0;
    #2;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_ctrl", out_ctrl_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_occ", occ_a, 0);
    chk("rst_stall", stall_a, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready_a, 1);

    // a: stream four entries with out_ready high
    out_ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid_a = 1'b1;
      in_ctrl_a  = CW'(i);
      in_data_a  = DW'(i * 256);
      #1;
      chk("stream_in_ready", in_ready_a, 1);
      tick();
      chk("stream_valid", out_valid_a, 1);
      chk("stream_ctrl", out_ctrl_a, i);
      chk("stream_data", out_data_a, i * 256);
      chk("stream_occ", occ_a, 1);
    end
    in_valid_a = 1'b0;
    tick();
    chk("bubble_valid", out_valid_a, 0);
    chk("bubble_ctrl", out_ctrl_a, 0);
    chk("bubble_data", out_data_a, 0);
    chk("stream_stall", stall_a, 0);

    // a: fill the skid buffer under back-pressure, then drain
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 16'hA; in_data_a = 32'hAA;
    tick();
    chk("fill1_occ", occ_a, 1);
    in_ctrl_a = 16'hB; in_data_a = 32'hBB;
    tick();
    chk("fill2_occ", occ_a, 2);
    chk("fill2_in_ready", in_ready_a, 0);
    chk("fill2_ctrl", out_ctrl_a, 16'hA);
    in_valid_a = 1'b0;
    tick();
    chk("hold_ctrl", out_ctrl_a, 16'hA);
    chk("hold_stall", stall_a, 2);
    out_ready_a = 1'b1;
    #1;
    chk("two_ready_no_comb", in_ready_a, 0);
    tick();
    chk("drain1_ctrl", out_ctrl_a, 16'hB);
    chk("drain1_data", out_data_a, 32'hBB);
    chk("drain1_occ", occ_a, 1);
    chk("drain1_in_ready", in_ready_a, 1);
    tick();
    chk("drain2_valid", out_valid_a, 0);
    chk("drain2_ctrl", out_ctrl_a, 0);
    chk("drain_stall", stall_a, 2);

    // a: flush while holding two entries, with a new input offered
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 16'h1; in_data_a = 32'h11;
    tick();
    in_ctrl_a = 16'h2; in_data_a = 32'h22;
    tick();
    chk("pre_flush_occ", occ_a, 2);
    flush_a = 1'b1; in_ctrl_a = 16'hC; in_data_a = 32'hCC;
    tick();
    chk("flush_valid", out_valid_a, 0);
    chk("flush_ctrl", out_ctrl_a, 0);
    chk("flush_data_clr", out_data_a, 0);
    chk("flush_occ", occ_a, 0);
    chk("flush_stall", stall_a, 3);
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    tick();
    chk("flush_dropped", out_valid_a, 0);

    // b: pass-through ready and same-edge replacement
    in_valid_b = 1'b1; in_ctrl_b = 16'h7; in_data_b = 32'h77; out_ready_b = 1'b0;
    #1;
    chk("b_empty_ready", in_ready_b, 1);
    tick();
    chk("b_ctrl7", out_ctrl_b, 16'h7);
    chk("b_stall_ready", in_ready_b, 0);
    in_ctrl_b = 16'h8; in_data_b = 32'h88; out_ready_b = 1'b1;
    #1;
    chk("b_comb_ready", in_ready_b, 1);
    tick();
    chk("b_replace_valid", out_valid_b, 1);
    chk("b_replace_ctrl", out_ctrl_b, 16'h8);
    chk("b_replace_data", out_data_b, 32'h88);
    chk("b_replace_occ", occ_b, 1);
    in_valid_b = 1'b0;
    tick();
    chk("b_empty_valid", out_valid_b, 0);
    chk("b_empty_ctrl", out_ctrl_b, 0);

    // c: saturating 2-bit stall counter, then flush holding data
    out_ready_c = 1'b0;
    in_valid_c  = 1'b1; in_ctrl_c = 16'h1; in_data_c = 32'hD1;
    tick();
    chk("c_stall0", stall_c, 0);
    in_ctrl_c = 16'h2; in_data_c = 32'hD2;
    for (int i = 0; i < 6; i++) begin
      tick();
      in_valid_c = 1'b0;
      chk("c_stall_sat", stall_c, sat_exp[i]);
    end
    chk("c_occ2", occ_c, 2);
    flush_c = 1'b1; in_valid_c = 1'b1; in_ctrl_c = 16'hC; in_data_c = 32'hCC;
    tick();
    chk("c_flush_valid", out_valid_c, 0);
    chk("c_flush_ctrl", out_ctrl_c, 0);
    chk("c_flush_data_held", out_data_c, 32'hD1);
    chk("c_flush_occ", occ_c, 0);
    flush_c = 1'b0; in_valid_c = 1'b0;
    tick();
    chk("c_flush_dropped", out_valid_c, 0);

    // a: asynchronous reset while holding two entries
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1; in_ctrl_a = 16'h5; in_data_a = 32'h55;
    tick();
    in_ctrl_a = 16'h6; in_data_a = 32'h66;
    tick();
    in_valid_a = 1'b0;
    chk("ar_pre_occ", occ_a, 2);
    chk("ar_pre_stall", stall_a, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid_a, 0);
    chk("ar_ctrl", out_ctrl_a, 0);
    chk("ar_data", out_data_a, 0);
    chk("ar_occ", occ_a, 0);
    chk("ar_stall", stall_a, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_post_occ", occ_a, 0);
    chk("ar_post_ready", in_ready_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
